// File: rtl/clock_set_core_if.sv
// Key / display bundle between the board keys, clock_set_core and the SevenSeg drivers.
// Optional 12 h signals exist only when CLOCK_SET_12H_EN is defined.
interface clock_set_core_if;
    logic [3:0]  key_n;
    logic [23:0] digits;
    logic [5:0]  digit_off;
    logic        set_mode;
    logic        sec_pulse;
`ifdef CLOCK_SET_12H_EN
    logic        mode_12h;
    logic        pm;

    modport master (output key_n, mode_12h, input digits, digit_off, set_mode, sec_pulse, pm);
    modport slave  (input key_n, mode_12h, output digits, digit_off, set_mode, sec_pulse, pm);
`else
    modport master (output key_n, input digits, digit_off, set_mode, sec_pulse);
    modport slave  (input key_n, output digits, digit_off, set_mode, sec_pulse);
`endif
endinterface

// File: rtl/clock_set_core.sv
// HH:MM:SS BCD timekeeper with key-driven set mode, field blink and seconds clear.
// Optional 12 h display (mode_12h/pm) is enabled by defining CLOCK_SET_12H_EN.
module clock_set_core #(
    parameter int          TICKS_PER_CENTISEC = 600000,
    parameter int          CENTISECS_PER_SEC  = 100,
    parameter int          BLINK_CENTISECS    = 50,
    parameter logic [23:0] INIT_TIME          = 24'h235949
) (
    input logic             clk_i,
    input logic             reset_i,
    clock_set_core_if.slave bus
);
    localparam int TW = $clog2(TICKS_PER_CENTISEC);
    localparam int CW = $clog2(CENTISECS_PER_SEC);
    localparam int BW = (BLINK_CENTISECS > 1) ? $clog2(BLINK_CENTISECS) : 1;
    localparam logic [TW-1:0] T_MAX = TW'(TICKS_PER_CENTISEC - 1);
    localparam logic [CW-1:0] C_MAX = CW'(CENTISECS_PER_SEC - 1);
    localparam logic [BW-1:0] B_MAX = BW'(BLINK_CENTISECS - 1);

    typedef enum logic [1:0] {DISP, SET_HRS, SET_MIN, SET_SEC} state_e;

    state_e        state_q, state_d;
    logic [7:0]    hrs_q, hrs_d, min_q, min_d, sec_q, sec_d;
    logic [TW-1:0] ticks_q, ticks_d;
    logic [CW-1:0] cs_q, cs_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          hidden_q, hidden_d;
    logic [5:0]    off_q, off_d;
    logic          pulse_q, pulse_d;
    logic [3:0]    sync1_q, sync2_q, prev_q;
    logic [3:0]    fall;
    logic          k0, k1, k2, k3, tick_wrap, cs_wrap;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] r;
        if (v == vmax)            r = 8'h00;
        else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
        else                      r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] r;
        if (v == 8'h00)           r = vmax;
        else if (v[3:0] == 4'd0)  r = {v[7:4] - 4'd1, 4'd9};
        else                      r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= bus.key_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Simultaneous presses collapse to the single highest-priority key.
    always_comb begin
        fall = prev_q & ~sync2_q;
        k0   = fall[0];
        k1   = fall[1] & ~fall[0];
        k2   = fall[2] & ~|fall[1:0];
        k3   = fall[3] & ~|fall[2:0];
        tick_wrap = (ticks_q == T_MAX);
        cs_wrap   = tick_wrap && (cs_q == C_MAX);
    end

    always_comb begin
        state_d  = state_q;
        hrs_d    = hrs_q;
        min_d    = min_q;
        sec_d    = sec_q;
        ticks_d  = tick_wrap ? '0 : ticks_q + 1'b1;
        cs_d     = cs_wrap ? '0 : (tick_wrap ? cs_q + 1'b1 : cs_q);
        blink_d  = blink_q;
        hidden_d = hidden_q;
        pulse_d  = 1'b0;
        off_d    = '0;

        case (state_q)
            DISP: begin
                if (cs_wrap && !k3) begin
                    sec_d   = bcd_inc(sec_q, 8'h59);
                    pulse_d = 1'b1;
                    if (sec_q == 8'h59) begin
                        min_d = bcd_inc(min_q, 8'h59);
                        if (min_q == 8'h59) hrs_d = bcd_inc(hrs_q, 8'h23);
                    end
                end
                if (k0) state_d = SET_HRS;
            end
            SET_HRS: begin
                if (k1) hrs_d = bcd_inc(hrs_q, 8'h23);
                if (k2) hrs_d = bcd_dec(hrs_q, 8'h23);
                if (k0) state_d = SET_MIN;
            end
            SET_MIN: begin
                if (k1) min_d = bcd_inc(min_q, 8'h59);
                if (k2) min_d = bcd_dec(min_q, 8'h59);
                if (k0) state_d = SET_SEC;
            end
            default: begin
                if (k1) sec_d = bcd_inc(sec_q, 8'h59);
                if (k2) sec_d = bcd_dec(sec_q, 8'h59);
                if (k0) begin
                    state_d = DISP;
                    ticks_d = '0;
                    cs_d    = '0;
                end
            end
        endcase

        if (k3) begin
            sec_d   = 8'h00;
            ticks_d = '0;
            cs_d    = '0;
        end

        // Blink runs in centiseconds; any navigation/adjust key restarts it visible.
        if (state_q == DISP || k0 || k1 || k2) begin
            blink_d  = '0;
            hidden_d = 1'b0;
        end else if (tick_wrap) begin
            if (blink_q == B_MAX) begin
                blink_d  = '0;
                hidden_d = ~hidden_q;
            end else begin
                blink_d = blink_q + 1'b1;
            end
        end

        if (hidden_d) begin
            case (state_d)
                SET_HRS: off_d = 6'b110000;
                SET_MIN: off_d = 6'b001100;
                SET_SEC: off_d = 6'b000011;
                default: off_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= DISP;
            hrs_q    <= INIT_TIME[23:16];
            min_q    <= INIT_TIME[15:8];
            sec_q    <= INIT_TIME[7:0];
            ticks_q  <= '0;
            cs_q     <= '0;
            blink_q  <= '0;
            hidden_q <= 1'b0;
            off_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hrs_q    <= hrs_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            ticks_q  <= ticks_d;
            cs_q     <= cs_d;
            blink_q  <= blink_d;
            hidden_q <= hidden_d;
            off_q    <= off_d;
            pulse_q  <= pulse_d;
        end
    end

    assign bus.set_mode  = (state_q != DISP);
    assign bus.sec_pulse = pulse_q;

`ifdef CLOCK_SET_12H_EN
    logic [4:0] hbin, hdisp;
    logic [7:0] hrs_show;

    // Internal hours stay 24 h; only the displayed pair is remapped to 12,01..11.
    always_comb begin
        hbin = 5'(hrs_q[7:4]) * 5'd10 + 5'(hrs_q[3:0]);
        if (hbin == 5'd0)       hdisp = 5'd12;
        else if (hbin > 5'd12)  hdisp = hbin - 5'd12;
        else                    hdisp = hbin;
        hrs_show = (hdisp >= 5'd10) ? {4'd1, 4'(hdisp - 5'd10)} : {4'd0, hdisp[3:0]};
    end

    assign bus.pm        = (hbin >= 5'd12);
    assign bus.digits    = {bus.mode_12h ? hrs_show : hrs_q, min_q, sec_q};
    assign bus.digit_off = off_q | {bus.mode_12h && (hrs_show[7:4] == 4'd0), 5'b0};
`else
    assign bus.digits    = {hrs_q, min_q, sec_q};
    assign bus.digit_off = off_q;
`endif
endmodule
